cla_seq_adder_ctrl: RTL



---
 rtl/cla_seq_adder_ctrl_if.sv | 29 ++
 rtl/cla_seq_adder_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for the sequential carry-lookahead adder.
// The controller is the slave; the operand issuer/result consumer is the master.
`timescale 1ns/1ps
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit carry-lookahead slice reused
// over WIDTH/4 cycles, LSB nibble first, with valid/ready on both sides.
`timescale 1ns/1ps
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  cla_seq_adder_ctrl_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = $clog2(NIB);
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [IDXW-1:0]         idx;
  logic                    carry;
  logic [NIB-1:0][3:0]     a_q;
  logic [NIB-1:0][3:0]     b_q;
  logic [NIB-1:0][3:0]     acc;
  logic [NIB-1:0][3:0]     sum_next;
  logic [WIDTH-1:0]        sum_q;
  logic                    cout_q;
  logic                    ovf_q;
  logic [4:0]              slice;
  logic                    ovf_next;

  // Two-level lookahead: every carry is a flat sum of products of g/p/c0.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] g, p, c;
    logic       c4;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ c};
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    slice         = cla4(a_q[idx], b_q[idx], carry);
    sum_next      = acc;
    sum_next[idx] = slice[3:0];
    ovf_next      = (a_q[NIB-1][3] == b_q[NIB-1][3]) && (sum_next[NIB-1][3] != a_q[NIB-1][3]);
  end

  // NOTE: operand registers carry no reset; they are always loaded before they are read.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_q <= bus.in_a;
      b_q <= bus.in_sub ? ~bus.in_b : bus.in_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      acc    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            carry <= bus.in_sub | bus.in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc[idx] <= slice[3:0];
          carry    <= slice[4];
          if (idx == LAST) begin
            sum_q  <= sum_next;
            cout_q <= slice[4];
            ovf_q  <= ovf_next;
            state  <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule
